// File: rtl/phaser_in_cal_ctrl_if.sv
// Phaser-in calibration controller bus: start/target request, phaser-in status and controls,
// and sequence status. The controller uses the master modport.
interface phaser_in_cal_ctrl_if;
    logic       START;
    logic [5:0] TARGET_TAP;
    logic       PHASELOCKED;
    logic       DQSFOUND;
    logic       DQSOUTOFRANGE;
    logic       FINEOVERFLOW;
    logic [5:0] COUNTERREADVAL;
    logic       RSTDQSFIND;
    logic       COUNTERLOADEN;
    logic       COUNTERREADEN;
    logic       FINEENABLE;
    logic       FINEINC;
    logic [5:0] COUNTERLOADVAL;
    logic       BUSY;
    logic       DONE;
    logic       ERR;
    logic [2:0] ERR_CODE;
    logic [5:0] FINE_TAPS;

    modport master (
        input  START, TARGET_TAP, PHASELOCKED, DQSFOUND, DQSOUTOFRANGE, FINEOVERFLOW,
               COUNTERREADVAL,
        output RSTDQSFIND, COUNTERLOADEN, COUNTERREADEN, FINEENABLE, FINEINC, COUNTERLOADVAL,
               BUSY, DONE, ERR, ERR_CODE, FINE_TAPS
    );

    modport slave (
        output START, TARGET_TAP, PHASELOCKED, DQSFOUND, DQSOUTOFRANGE, FINEOVERFLOW,
               COUNTERREADVAL,
        input  RSTDQSFIND, COUNTERLOADEN, COUNTERREADEN, FINEENABLE, FINEINC, COUNTERLOADVAL,
               BUSY, DONE, ERR, ERR_CODE, FINE_TAPS
    );
endinterface

// File: rtl/phaser_in_cal_ctrl.sv
// Phaser-in calibration sequencer: wait for lock, find DQS, load coarse, walk fine taps.
// Define PHASER_IN_CAL_READBACK_EN to add a counter readback check after the coarse load.
module phaser_in_cal_ctrl #(
    parameter int unsigned LOCK_TIMEOUT  = 1023,
    parameter int unsigned SETTLE_CYCLES = 8,
    parameter logic [5:0]  COARSE_LOAD   = 6'd0
) (
    input logic                   SYSCLK,
    input logic                   RST_N,
    phaser_in_cal_ctrl_if.master  bus
);
    localparam int unsigned     ToW        = $clog2(LOCK_TIMEOUT + 1);
    localparam int unsigned     CntW       = (ToW > 8) ? ToW : 8;
    localparam logic [CntW-1:0] ToMax      = CntW'(LOCK_TIMEOUT);
    localparam logic [CntW-1:0] SettleLast = CntW'(SETTLE_CYCLES - 1);

    typedef enum logic [3:0] {
        StIdle, StWaitLock, StDqsRst, StDqsWait, StLoad, StReadback,
        StFine, StGap, StSettle, StDone, StError
    } state_e;

    localparam logic [2:0] ErrLock     = 3'b000;
    localparam logic [2:0] ErrTimeout  = 3'b001;
    localparam logic [2:0] ErrDqsRange = 3'b010;
    localparam logic [2:0] ErrFineOvf  = 3'b011;
    localparam logic [2:0] ErrReadback = 3'b100;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [5:0]      target_q, target_d;
    logic [5:0]      taps_q, taps_d;
    logic [2:0]      err_code_q, err_code_d;
    logic            fine_en, fine_inc;
`ifdef PHASER_IN_CAL_READBACK_EN
    logic            rd_en;
`else
    logic            unused_readval;
    assign unused_readval = ^bus.COUNTERREADVAL;
`endif

    always_ff @(posedge SYSCLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            target_q   <= '0;
            taps_q     <= '0;
            err_code_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            target_q   <= target_d;
            taps_q     <= taps_d;
            err_code_q <= err_code_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + CntW'(1);
        target_d   = target_q;
        taps_d     = taps_q;
        err_code_d = err_code_q;
        fine_en    = 1'b0;
        fine_inc   = 1'b0;
`ifdef PHASER_IN_CAL_READBACK_EN
        rd_en      = 1'b0;
`endif
        unique case (state_q)
            StIdle, StDone, StError: begin
                cnt_d = '0;
                if (bus.START) begin
                    state_d    = StWaitLock;
                    target_d   = bus.TARGET_TAP;
                    err_code_d = 3'b000;
                end
            end
            StWaitLock: begin
                if (bus.PHASELOCKED) begin
                    state_d = StDqsRst;
                end else if (cnt_q == ToMax) begin
                    state_d    = StError;
                    err_code_d = ErrTimeout;
                end
            end
            StDqsRst: state_d = StDqsWait;
            StDqsWait: begin
                if (bus.DQSOUTOFRANGE) begin
                    state_d    = StError;
                    err_code_d = ErrDqsRange;
                end else if (bus.DQSFOUND) begin
                    state_d = StLoad;
                end else if (cnt_q == ToMax) begin
                    state_d    = StError;
                    err_code_d = ErrTimeout;
                end
            end
`ifdef PHASER_IN_CAL_READBACK_EN
            StLoad: state_d = StReadback;
            StReadback: begin
                // Read enable on the first cycle; readback data is valid two cycles later.
                rd_en = (cnt_q == '0);
                if (cnt_q == CntW'(2)) begin
                    if (bus.COUNTERREADVAL != COARSE_LOAD) begin
                        state_d    = StError;
                        err_code_d = ErrReadback;
                    end else begin
                        state_d = StFine;
                    end
                end
            end
`else
            StLoad: state_d = StFine;
`endif
            StFine: begin
                if (bus.FINEOVERFLOW) begin
                    state_d    = StError;
                    err_code_d = ErrFineOvf;
                end else if (taps_q == target_q) begin
                    state_d = StSettle;
                end else begin
                    fine_en  = 1'b1;
                    fine_inc = (taps_q < target_q);
                    if (fine_inc && taps_q != 6'd63) begin
                        taps_d = taps_q + 6'd1;
                    end else if (!fine_inc && taps_q != 6'd0) begin
                        taps_d = taps_q - 6'd1;
                    end
                    state_d = StGap;
                end
            end
            StGap: begin
                if (bus.FINEOVERFLOW) begin
                    state_d    = StError;
                    err_code_d = ErrFineOvf;
                end else if (cnt_q == SettleLast) begin
                    state_d = StFine;
                end
            end
            StSettle: begin
                if (cnt_q == SettleLast) begin
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase

        // Loss of lock overrides every other decision, including a pending fine step.
        if (state_q inside {StDqsRst, StDqsWait, StLoad, StReadback, StFine, StGap, StSettle}
            && !bus.PHASELOCKED) begin
            state_d    = StError;
            err_code_d = ErrLock;
            fine_en    = 1'b0;
            fine_inc   = 1'b0;
            taps_d     = taps_q;
        end

        if (state_d != state_q) begin
            cnt_d = '0;
        end
    end

    assign bus.RSTDQSFIND     = (state_q == StDqsRst);
    assign bus.COUNTERLOADEN  = (state_q == StLoad);
    assign bus.COUNTERLOADVAL = (state_q == StLoad) ? COARSE_LOAD : 6'd0;
`ifdef PHASER_IN_CAL_READBACK_EN
    assign bus.COUNTERREADEN  = rd_en;
`else
    assign bus.COUNTERREADEN  = 1'b0;
`endif
    assign bus.FINEENABLE     = fine_en;
    assign bus.FINEINC        = fine_inc;
    assign bus.BUSY           = !(state_q inside {StIdle, StDone, StError});
    assign bus.DONE           = (state_q == StDone);
    assign bus.ERR            = (state_q == StError);
    assign bus.ERR_CODE       = err_code_q;
    assign bus.FINE_TAPS      = taps_q;
endmodule

// File: tb/tb_phaser_in_cal_ctrl.sv
// Directed bench for phaser_in_cal_ctrl: expected fine steps are queued when a run is launched
// and popped as FINEENABLE pulses appear; sequence results are checked when DONE/ERR rise.
`timescale 1ns/1ps
module tb_phaser_in_cal_ctrl;
    localparam logic [5:0]  CoarseLoad = 6'h2A;
    localparam int unsigned Settle     = 8;
`ifdef PHASER_IN_CAL_READBACK_EN
    localparam int          RbExtra    = 3;
`else
    localparam int          RbExtra    = 0;
`endif

    typedef struct packed {
        logic       inc;
        logic [5:0] taps;
    } step_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    phaser_in_cal_ctrl_if bus ();

    phaser_in_cal_ctrl #(
        .LOCK_TIMEOUT (15),
        .SETTLE_CYCLES(Settle),
        .COARSE_LOAD  (CoarseLoad)
    ) dut (
        .SYSCLK(clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    step_t      exp_q[$];
    int         pulse_cyc[$];
    step_t      mon_e;
    int         checks = 0;
    int         errors = 0;
    int         cycle = 0;
    int         n_rst = 0;
    int         n_load = 0;
    int         n_rd = 0;
    logic [5:0] model_taps = 6'd0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({bus.RSTDQSFIND, bus.COUNTERLOADEN, bus.COUNTERREADEN, bus.FINEENABLE,
                    bus.FINEINC, bus.COUNTERLOADVAL, bus.BUSY, bus.DONE, bus.ERR,
                    bus.ERR_CODE, bus.FINE_TAPS});
    endfunction

    function automatic logic [31:0] ctrl_outs();
        return 32'({bus.RSTDQSFIND, bus.COUNTERLOADEN, bus.COUNTERREADEN, bus.FINEENABLE,
                    bus.FINEINC, bus.COUNTERLOADVAL});
    endfunction

    // Monitor: consumes queued fine-step expectations and counts control pulses.
    always @(negedge clk) begin
        cycle++;
        if (bus.RSTDQSFIND) n_rst++;
        if (bus.COUNTERREADEN) n_rd++;
        if (bus.COUNTERLOADEN) begin
            n_load++;
            check("load_val", 32'(bus.COUNTERLOADVAL), 32'(CoarseLoad));
        end
        if (bus.FINEENABLE) begin
            check("step_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                check("fine_inc", 32'(bus.FINEINC), 32'(mon_e.inc));
                check("step_taps", 32'(bus.FINE_TAPS), 32'(mon_e.taps));
            end
            pulse_cyc.push_back(cycle);
        end
    end

    function automatic int plan(input logic [5:0] tgt);
        int n = 0;
        logic [5:0] m = model_taps;
        while (m != tgt) begin
            exp_q.push_back({(m < tgt), m});
            m = (m < tgt) ? m + 6'd1 : m - 6'd1;
            n++;
        end
        model_taps = tgt;
        return n;
    endfunction

    task automatic start_run(input logic [5:0] tgt);
        bus.TARGET_TAP = tgt;
        bus.START = 1'b1;
        @(negedge clk);
        bus.START = 1'b0;
        check("busy_after_start", 32'(bus.BUSY), 32'd1);
        check("flags_cleared", 32'({bus.DONE, bus.ERR, bus.ERR_CODE}), 32'd0);
    endtask

    // Waits for DONE or ERR; optionally pokes a START while busy, which must be ignored.
    task automatic wait_end(input int poke_at, output int cyc);
        cyc = 0;
        while (!(bus.DONE || bus.ERR) && cyc < 3000) begin
            bus.START = (cyc == poke_at);
            bus.TARGET_TAP = (cyc == poke_at) ? 6'd40 : bus.TARGET_TAP;
            @(negedge clk);
            cyc++;
        end
        bus.START = 1'b0;
        check("end_reached", 32'(bus.DONE || bus.ERR), 32'd1);
    endtask

    task automatic normal_run(input logic [5:0] tgt, input int poke_at);
        int cyc, r0, l0, n;
        r0 = n_rst;
        l0 = n_load;
        pulse_cyc.delete();
        n = plan(tgt);
        start_run(tgt);
        wait_end(poke_at, cyc);
        check("done_latency", 32'(cyc), 32'(13 + RbExtra + n * (Settle + 1)));
        check("done", 32'(bus.DONE), 32'd1);
        check("err_clear", 32'(bus.ERR), 32'd0);
        check("busy_idle", 32'(bus.BUSY), 32'd0);
        check("fine_taps", 32'(bus.FINE_TAPS), 32'(model_taps));
        check("steps_left", 32'(exp_q.size()), 32'd0);
        check("step_count", 32'(pulse_cyc.size()), 32'(n));
        for (int i = 1; i < pulse_cyc.size(); i++) begin
            check("step_spacing", 32'(pulse_cyc[i] - pulse_cyc[i-1]), 32'(Settle + 1));
        end
        check("rstdqs_pulses", 32'(n_rst - r0), 32'd1);
        check("load_pulses", 32'(n_load - l0), 32'd1);
        repeat (3) @(negedge clk);
        check("done_held", 32'(bus.DONE), 32'd1);
    endtask

    task automatic gap_abort(input logic [5:0] tgt, input bit drop_lock,
                             input logic [2:0] code, input logic [5:0] taps_after);
        int k = 0;
        pulse_cyc.delete();
        exp_q.push_back({(model_taps < tgt), model_taps});
        start_run(tgt);
        while (pulse_cyc.size() == 0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("gap_pulse_seen", 32'(pulse_cyc.size()), 32'd1);
        repeat (3) @(negedge clk);
        if (drop_lock) bus.PHASELOCKED = 1'b0;
        else bus.FINEOVERFLOW = 1'b1;
        @(negedge clk);
        check("gap_abort_err", 32'(bus.ERR), 32'd1);
        check("gap_abort_code", 32'(bus.ERR_CODE), 32'(code));
        check("gap_abort_taps", 32'(bus.FINE_TAPS), 32'(taps_after));
        check("gap_abort_ctrl", ctrl_outs(), 32'd0);
        bus.PHASELOCKED = 1'b1;
        bus.FINEOVERFLOW = 1'b0;
        exp_q.delete();
        model_taps = taps_after;
    endtask

    initial begin
        int cyc, r0, l0, k;
        bus.START = 1'b0;
        bus.TARGET_TAP = 6'd0;
        bus.PHASELOCKED = 1'b1;
        bus.DQSFOUND = 1'b1;
        bus.DQSOUTOFRANGE = 1'b0;
        bus.FINEOVERFLOW = 1'b0;
        bus.COUNTERREADVAL = CoarseLoad;

        repeat (2) @(negedge clk);
        check("reset_outs", all_outs(), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_outs", all_outs(), 32'd0);

        // Ramp up to 5; a START poked mid-sequence must not retarget it.
        normal_run(6'd5, 20);
        normal_run(6'd2, -1);
        normal_run(6'd2, -1);

        // Lock never arrives: timeout after LOCK_TIMEOUT+1 cycles.
        bus.PHASELOCKED = 1'b0;
        r0 = n_rst;
        start_run(6'd7);
        wait_end(-1, cyc);
        check("timeout_latency", 32'(cyc), 32'd16);
        check("timeout_code", 32'({bus.ERR, bus.ERR_CODE}), 32'({1'b1, 3'b001}));
        check("timeout_busy", 32'(bus.BUSY), 32'd0);
        check("timeout_no_rstdqs", 32'(n_rst - r0), 32'd0);
        check("timeout_taps", 32'(bus.FINE_TAPS), 32'(model_taps));
        bus.PHASELOCKED = 1'b1;

        // Out-of-range wins over a simultaneous DQSFOUND.
        bus.DQSOUTOFRANGE = 1'b1;
        l0 = n_load;
        start_run(6'd9);
        wait_end(-1, cyc);
        check("dqs_range_latency", 32'(cyc), 32'd3);
        check("dqs_range_code", 32'({bus.ERR, bus.ERR_CODE}), 32'({1'b1, 3'b010}));
        check("dqs_range_no_load", 32'(n_load - l0), 32'd0);
        check("dqs_range_ctrl", ctrl_outs(), 32'd0);
        bus.DQSOUTOFRANGE = 1'b0;

        gap_abort(6'd6, 1'b1, 3'b000, 6'd3);
        gap_abort(6'd0, 1'b0, 3'b011, 6'd2);

        // Asynchronous reset while a fine step is on the bus.
        exp_q.push_back({1'b1, model_taps});
        start_run(6'd10);
        k = 0;
        while (!bus.FINEENABLE && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("fine_seen", 32'(bus.FINEENABLE), 32'd1);
        #1 rst_n = 1'b0;
        #1 check("reset_in_fine", all_outs(), 32'd0);
        exp_q.delete();
        model_taps = 6'd0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("after_reset", all_outs(), 32'd0);

        normal_run(6'd1, -1);
        normal_run(6'd63, -1);
        normal_run(6'd63, -1);
        normal_run(6'd0, -1);

`ifdef PHASER_IN_CAL_READBACK_EN
        bus.COUNTERREADVAL = CoarseLoad ^ 6'h01;
        r0 = n_rd;
        start_run(6'd4);
        wait_end(-1, cyc);
        check("readback_code", 32'({bus.ERR, bus.ERR_CODE}), 32'({1'b1, 3'b100}));
        check("readback_pulse", 32'(n_rd - r0), 32'd1);
        check("readback_taps", 32'(bus.FINE_TAPS), 32'(model_taps));
        bus.COUNTERREADVAL = CoarseLoad;
`else
        check("readen_never", 32'(n_rd), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
